key_input: RTL and testbench

KEY_INPUT -- requirements
Module: key_input

---
 rtl/matrix_calc_pkg.sv | 20 ++
 rtl/key_channel.sv | 137 +++++++++++++
 rtl/key_input.sv | 52 +++++
 tb/tb_key_input.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_calc_pkg.sv
// Shared constants and key state encoding for the push-button front end.
package matrix_calc_pkg;

  localparam int unsigned CLK_FREQ         = 50_000_000;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;   // 20 ms
  localparam int unsigned LONG_CYC_DEF     = 50_000_000;  // 1 s
  localparam int unsigned REPEAT_CYC_DEF   = 10_000_000;  // 200 ms

  localparam int unsigned CNT_W     = 26;
  localparam int unsigned CNT_LIMIT = 2 ** CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    KeyIdle = 2'd0,
    KeyHeld = 2'd1,
    KeyLong = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_channel.sv
// One push-button: 2-flop synchronizer, debounce counter and short/long/repeat FSM.
// Auto-repeat exists only when KEY_REPEAT_EN is defined.
module key_channel
  import matrix_calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic level_nxt,
  output logic short_p,
  output logic long_p,
  output logic rpt_p
);

  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1 ||
      DEBOUNCE_CYC > CNT_LIMIT || LONG_CYC > CNT_LIMIT || REPEAT_CYC > CNT_LIMIT)
  begin : g_param_chk
    $fatal(1, "key_channel: cycle parameters must lie in 1..2**26");
  end

  logic [1:0] sync_q;
  logic       level_q, level_d;
  cnt_t       db_cnt_q, db_cnt_d;
  key_state_e state_q, state_d;
  cnt_t       hold_q, hold_d;
  logic       short_q, short_d;
  logic       long_q, long_d;

  // Counter only runs while the synchronized input disagrees with the level.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == cnt_t'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      KeyIdle: begin
        if (level_q) begin
          state_d = KeyHeld;
          hold_d  = '0;
        end
      end
      KeyHeld: begin
        if (!level_q) begin
          state_d = KeyIdle;
          short_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
          if (hold_d >= cnt_t'(LONG_CYC - 1)) begin
            state_d = KeyLong;
            long_d  = 1'b1;
          end
        end
      end
      KeyLong: begin
        if (!level_q) begin
          state_d = KeyIdle;
        end
      end
      default: state_d = KeyIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= KeyIdle;
      hold_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      short_q  <= short_d;
      long_q   <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  cnt_t rpt_cnt_q, rpt_cnt_d;
  logic rpt_q, rpt_d;

  // Held at zero outside LONG, so it starts from 0 on LONG entry.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_d     = 1'b0;
    if (state_q == KeyLong && level_q) begin
      if (rpt_cnt_q == cnt_t'(REPEAT_CYC - 1)) begin
        rpt_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign rpt_p = rpt_q;
`else
  assign rpt_p = 1'b0;
`endif

  assign level     = level_q;
  assign level_nxt = level_d;
  assign short_p   = short_q;
  assign long_p    = long_q;

endmodule

// File: rtl/key_input.sv
// N_KEYS independent debounced push-buttons with short/long/repeat pulses.
// Define KEY_REPEAT_EN to enable the auto-repeat pulse on key_rpt.
module key_input
  import matrix_calc_pkg::*;
#(
  parameter int unsigned N_KEYS       = 3,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_short,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_rpt,
  output logic              key_any
);

  logic [N_KEYS-1:0] level_nxt;
  logic              any_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .raw      (key_raw[i]),
      .level    (key_level[i]),
      .level_nxt(level_nxt[i]),
      .short_p  (key_short[i]),
      .long_p   (key_long[i]),
      .rpt_p    (key_rpt[i])
    );
  end

  // Registered from the next-state levels so key_any tracks key_level cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |level_nxt;
    end
  end

  assign key_any = any_q;

endmodule

// File: tb/tb_key_input.sv
// Scoreboard bench for key_input with DEBOUNCE_CYC=10, LONG_CYC=100, REPEAT_CYC=20.
module tb_key_input;

  localparam int NK = 3;
  localparam int KLRISE = 0, KLFALL = 1, KSHORT = 2, KLONG = 3, KRPT = 4, KARISE = 5, KAFALL = 6;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level, key_short, key_long, key_rpt;
  logic          key_any;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  logic [NK-1:0] lvl_prev = '0;
  logic          any_prev = 1'b0;
  bit   done = 1'b0;
  bit   flushed = 1'b0;

  key_input #(
    .N_KEYS      (NK),
    .DEBOUNCE_CYC(10),
    .LONG_CYC    (100),
    .REPEAT_CYC  (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .key_level(key_level),
    .key_short(key_short),
    .key_long (key_long),
    .key_rpt  (key_rpt),
    .key_any  (key_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      KLRISE:  return "level_rise";
      KLFALL:  return "level_fall";
      KSHORT:  return "key_short";
      KLONG:   return "key_long";
      KRPT:    return "key_rpt";
      KARISE:  return "any_rise";
      default: return "any_fall";
    endcase
  endfunction

  task automatic expect_ev(int c, int kind, int key);
    exp_q.push_back('{cyc: c, kind: kind, key: key});
  endtask

  // Pressed (raw) at tp, released at tr, relative to the drive cycle.
  task automatic key_events(int k, int tp, int tr);
    expect_ev(tp + 12, KLRISE, k);
    expect_ev(tr + 12, KLFALL, k);
    if (tr - tp >= 100) begin
      expect_ev(tp + 112, KLONG, k);
`ifdef KEY_REPEAT_EN
      // Repeat still fires on the edge where the level falls: the FSM sees the old level.
      for (int t = tp + 132; t <= tr + 12; t += 20) expect_ev(t, KRPT, k);
`endif
    end else begin
      expect_ev(tr + 13, KSHORT, k);
    end
  endtask

  task automatic observe(int kind, int key);
    int idx = -1;
    vectors++;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == kind && exp_q[i].key == key) idx = i;
    end
    if (idx < 0) begin
      miscompares++;
      $display("FAIL %s key%0d cycle %0d: got event, required none", kname(kind), key, cyc);
    end else begin
      exp_q.delete(idx);
    end
  endtask

  // Monitor: turns every output event into a scoreboard lookup.
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ({key_level, key_short, key_long, key_rpt, key_any} != '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b required 0", cyc,
                 {key_level, key_short, key_long, key_rpt, key_any});
      end
    end
    for (int k = 0; k < NK; k++) begin
      if (key_level[k] && !lvl_prev[k]) observe(KLRISE, k);
      if (!key_level[k] && lvl_prev[k]) observe(KLFALL, k);
      if (key_short[k]) observe(KSHORT, k);
      if (key_long[k]) observe(KLONG, k);
      if (key_rpt[k]) observe(KRPT, k);
    end
    if (key_any && !any_prev) observe(KARISE, 0);
    if (!key_any && any_prev) observe(KAFALL, 0);
    lvl_prev = key_level;
    any_prev = key_any;
    if (done && !flushed) begin
      foreach (exp_q[i]) begin
        vectors++;
        miscompares++;
        $display("FAIL %s key%0d cycle %0d: got no event, required one",
                 kname(exp_q[i].kind), exp_q[i].key, exp_q[i].cyc);
      end
      exp_q.delete();
      flushed = 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    tick(5);
    rst = 1'b0;
    tick(5);

    // Single short press on key0.
    t0 = cyc;
    key_events(0, t0, t0 + 50);
    expect_ev(t0 + 12, KARISE, 0);
    expect_ev(t0 + 62, KAFALL, 0);
    key_raw[0] = 1'b1;
    tick(50);
    key_raw[0] = 1'b0;
    tick(80);

    // Bouncing key1: nothing may come out.
    for (int i = 0; i < 10; i++) begin
      key_raw[1] = (i % 2 == 0);
      tick(4);
    end
    key_raw[1] = 1'b0;
    tick(30);

    // Long hold on key2.
    t0 = cyc;
    key_events(2, t0, t0 + 200);
    expect_ev(t0 + 12, KARISE, 0);
    expect_ev(t0 + 212, KAFALL, 0);
    key_raw[2] = 1'b1;
    tick(200);
    key_raw[2] = 1'b0;
    tick(40);

    // Keys 0 and 1 together.
    t0 = cyc;
    key_events(0, t0, t0 + 30);
    key_events(1, t0, t0 + 30);
    expect_ev(t0 + 12, KARISE, 0);
    expect_ev(t0 + 42, KAFALL, 0);
    key_raw[1:0] = 2'b11;
    tick(30);
    key_raw[1:0] = 2'b00;
    tick(40);

    // Reset in the middle of a key0 hold; the held key re-presses after release.
    t0 = cyc;
    expect_ev(t0 + 12, KLRISE, 0);
    expect_ev(t0 + 12, KARISE, 0);
    expect_ev(t0 + 50, KLFALL, 0);
    expect_ev(t0 + 50, KAFALL, 0);
    key_events(0, t0 + 60, t0 + 200);
    expect_ev(t0 + 72, KARISE, 0);
    expect_ev(t0 + 212, KAFALL, 0);
    key_raw[0] = 1'b1;
    tick(50);
    rst = 1'b1;
    tick(10);
    rst = 1'b0;
    tick(140);
    key_raw[0] = 1'b0;
    tick(40);

    // Very long hold on key0: exactly one key_long.
    t0 = cyc;
    key_events(0, t0, t0 + 300);
    expect_ev(t0 + 12, KARISE, 0);
    expect_ev(t0 + 312, KAFALL, 0);
    key_raw[0] = 1'b1;
    tick(300);
    key_raw[0] = 1'b0;
    tick(40);

    done = 1'b1;
    wait (flushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
